// File: rtl/heavyhash_pkg.sv
// Shared parameters and state encoding for the heavyhash matrix datapath and
// its downstream XOR/packing stage.
package heavyhash_pkg;

  localparam int PROD_W  = 16;
  localparam int LANES   = 4;
  localparam int WORDS   = 16;
  localparam int HASH_W  = 256;
  localparam int NIB_MSB = 13;
  localparam int NIB_LSB = 10;

  localparam int NIB_W  = NIB_MSB - NIB_LSB + 1;
  localparam int NPROD  = LANES * WORDS;
  localparam int WORD_W = LANES * PROD_W;
  localparam int CNT_W  = $clog2(WORDS + 1);
  localparam int IDX_W  = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    XOR,
    OUT
  } state_t;

endpackage

// File: rtl/heavyhash_xor_packer_nibble_pack.sv
// Combinational reduction of 64 dot products to their result nibbles, packed
// two per byte, plus a flag for any product exceeding the nibble's range.
module nibble_pack
  import heavyhash_pkg::*;
(
  input  logic [NPROD*PROD_W-1:0] prods,
  output logic [HASH_W-1:0]       packed_vec,
  output logic                    range_any
);

  always_comb begin
    packed_vec = '0;
    range_any  = 1'b0;
    for (int n = 0; n < NPROD; n++) begin
      range_any = range_any | (|prods[PROD_W*n + NIB_MSB + 1 +: PROD_W - NIB_MSB - 1]);
      // Even product index lands in the high nibble of its byte, odd in the low.
      packed_vec[NIB_W*(n ^ 1) +: NIB_W] = prods[PROD_W*n + NIB_LSB +: NIB_W];
    end
  end

endmodule

// File: rtl/heavyhash_xor_packer.sv
// Drains one hash worth of products, reduces and packs them, XORs with the
// original hash and offers the digest downstream over valid/ready.
module heavyhash_xor_packer
  import heavyhash_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_empty,
  input  logic [WORD_W-1:0] prod_data,
  output logic              prod_re,
  input  logic              orig_empty,
  input  logic [HASH_W-1:0] orig_data,
  output logic              orig_re,
  output logic              out_valid,
  output logic [HASH_W-1:0] out_data,
  input  logic              out_ready,
  output logic              range_err
);

  state_t state, next_state;

  logic [CNT_W-1:0]             issued;
  logic [CNT_W-1:0]             received;
  logic                         prod_pending;
  logic                         orig_pending;
  logic [WORDS-1:0][WORD_W-1:0] word_buf;
  logic [HASH_W-1:0]            hash_reg;
  logic [HASH_W-1:0]            packed_vec;
  logic                         range_any;

  nibble_pack u_nibble_pack (
    .prods      (word_buf),
    .packed_vec (packed_vec),
    .range_any  (range_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Leave COLLECT on the cycle the last word lands so XOR follows directly.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!orig_empty) next_state = COLLECT;
      COLLECT: if (prod_pending && received == CNT_W'(WORDS - 1)) next_state = XOR;
      XOR:     next_state = OUT;
      OUT:     if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // orig_re is gated by rst so no read escapes while reset holds the FSM in IDLE.
  always_comb begin
    prod_re   = 1'b0;
    orig_re   = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    orig_re   = !orig_empty && !rst;
      COLLECT: prod_re   = !prod_empty && (issued < CNT_W'(WORDS));
      OUT:     out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued       <= '0;
      received     <= '0;
      prod_pending <= 1'b0;
      orig_pending <= 1'b0;
      word_buf     <= '0;
      hash_reg     <= '0;
      out_data     <= '0;
      range_err    <= 1'b0;
    end else begin
      prod_pending <= prod_re;
      orig_pending <= orig_re;
      if (state == IDLE) begin
        issued   <= '0;
        received <= '0;
      end else begin
        if (prod_re) issued <= issued + CNT_W'(1);
        if (prod_pending) begin
          word_buf[received[IDX_W-1:0]] <= prod_data;
          received                      <= received + CNT_W'(1);
        end
      end
      if (orig_pending) hash_reg <= orig_data;
      if (state == XOR) begin
        out_data  <= packed_vec ^ hash_reg;
        range_err <= range_err | range_any;
      end
    end
  end

endmodule

// File: tb/tb_heavyhash_xor_packer.sv
// Directed and randomized bench for heavyhash_xor_packer with modelled FIFOs
// and a nibble-arithmetic reference digest.
module tb_heavyhash_xor_packer;
  import heavyhash_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              prod_empty;
  logic [WORD_W-1:0] prod_data;
  logic              prod_re;
  logic              orig_empty;
  logic [HASH_W-1:0] orig_data;
  logic              orig_re;
  logic              out_valid;
  logic [HASH_W-1:0] out_data;
  logic              out_ready;
  logic              range_err;

  heavyhash_xor_packer dut (
    .clk        (clk),
    .rst        (rst),
    .prod_empty (prod_empty),
    .prod_data  (prod_data),
    .prod_re    (prod_re),
    .orig_empty (orig_empty),
    .orig_data  (orig_data),
    .orig_re    (orig_re),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .range_err  (range_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0]  pq[$];
  logic [255:0] oq[$];
  logic [15:0]  prods[64];
  logic [255:0] orig_val;
  bit           stall_en, stall_phase, sticky;
  int           hold_left, cyc, prod_reads, orig_reads;
  logic         s_pre, s_ore, s_valid, s_ready;
  logic [255:0] s_data, got, ramp_got;

  task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive FIFO flags and ready, sample outputs, deliver read data.
  task automatic apply_stimulus();
    @(negedge clk);
    orig_empty  = (oq.size() == 0);
    stall_phase = ~stall_phase;
    prod_empty  = (pq.size() == 0) || (stall_en && stall_phase);
    if (out_valid && hold_left > 0) begin
      out_ready = 1'b0;
      hold_left--;
    end else begin
      out_ready = 1'b1;
    end
    #1;
    s_pre = prod_re; s_ore = orig_re; s_valid = out_valid; s_ready = out_ready; s_data = out_data;
    @(posedge clk);
    #1;
    if (s_pre) begin
      prod_reads++;
      if (pq.size() > 0) prod_data = pq.pop_front();
    end
    if (s_ore) begin
      orig_reads++;
      if (oq.size() > 0) orig_data = oq.pop_front();
    end
    cyc++;
  endtask

  function automatic logic [255:0] ref_digest();
    logic [255:0] r;
    int hi, lo;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      hi = (int'(prods[2*i]) / 1024) % 16;
      lo = (int'(prods[2*i+1]) / 1024) % 16;
      r[8*i +: 8] = 8'(hi * 16 + lo) ^ orig_val[8*i +: 8];
    end
    return r;
  endfunction

  function automatic bit ref_range();
    bit r;
    r = 1'b0;
    for (int n = 0; n < 64; n++) if (prods[n] >= 16'h4000) r = 1'b1;
    return r;
  endfunction

  task automatic load_queues();
    logic [63:0] w;
    for (int wi = 0; wi < 16; wi++) begin
      for (int l = 0; l < 4; l++) w[16*l +: 16] = prods[4*wi + l];
      pq.push_back(w);
    end
    oq.push_back(orig_val);
    prod_reads = 0;
    orig_reads = 0;
  endtask

  task automatic random_prods(input bit masked);
    for (int n = 0; n < 64; n++) begin
      prods[n] = 16'($urandom);
      if (masked) prods[n] = prods[n] & 16'h3FFF;
    end
    orig_val = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic run_hash(input string tag, input bit stall, input int hold, input bit check_latency,
                          output logic [255:0] digest);
    logic [255:0] exp;
    bit exp_rng, done;
    int start_ore, first_v;
    exp = ref_digest();
    exp_rng = ref_range();
    load_queues();
    stall_en = stall; hold_left = hold;
    start_ore = -1; first_v = -1; done = 1'b0; digest = '0;
    for (int k = 0; k < 400 && !done; k++) begin
      apply_stimulus();
      if (s_ore && start_ore < 0) start_ore = cyc - 1;
      if (s_valid) begin
        if (first_v < 0) begin
          first_v = cyc - 1;
          digest  = s_data;
        end else begin
          check_output({tag, " held data"}, s_data, digest);
          check_output({tag, " reads while held"}, {s_pre, s_ore}, 2'b00);
        end
        if (s_ready) done = 1'b1;
      end
    end
    stall_en = 1'b0;
    check_output({tag, " handshake"}, done, 1);
    check_output({tag, " digest"}, digest, exp);
    check_output({tag, " prod reads"}, prod_reads, 16);
    check_output({tag, " orig reads"}, orig_reads, 1);
    if (check_latency) check_output({tag, " latency"}, first_v - start_ore, 19);
    sticky = sticky | exp_rng;
    check_output({tag, " range_err"}, range_err, sticky);
    apply_stimulus();
    check_output({tag, " valid drop"}, s_valid, 0);
  endtask

  initial begin
    rst = 1'b1; prod_empty = 1'b0; orig_empty = 1'b0; out_ready = 1'b1;
    prod_data = '0; orig_data = '0; stall_en = 1'b0; stall_phase = 1'b0;
    sticky = 1'b0; hold_left = 0; cyc = 0; prod_reads = 0; orig_reads = 0;
    repeat (2) @(negedge clk);
    #1;
    check_output("reset prod_re", prod_re, 0);
    check_output("reset orig_re", orig_re, 0);
    check_output("reset out_valid", out_valid, 0);
    check_output("reset out_data", out_data, 0);
    check_output("reset range_err", range_err, 0);
    @(negedge clk);
    rst = 1'b0; orig_empty = 1'b1; prod_empty = 1'b1;

    for (int n = 0; n < 64; n++) prods[n] = 16'h0400;
    orig_val = '0;
    run_hash("const", 1'b0, 0, 1'b1, got);

    for (int n = 0; n < 64; n++) prods[n] = 16'((n % 16) << 10);
    orig_val = '1;
    run_hash("ramp", 1'b0, 0, 1'b1, ramp_got);
    run_hash("stall", 1'b1, 0, 1'b0, got);
    check_output("stall vs no-stall", got, ramp_got);

    random_prods(1'b1);
    run_hash("hold", 1'b0, 10, 1'b0, got);

    random_prods(1'b1);
    prods[$urandom_range(63, 0)] = 16'hC400;
    run_hash("range set", 1'b0, 0, 1'b1, got);
    random_prods(1'b1);
    run_hash("range sticky", 1'b0, 0, 1'b1, got);

    random_prods(1'b0);
    load_queues();
    for (int k = 0; k < 100 && prod_reads < 7; k++) apply_stimulus();
    check_output("mid-hash words read", prod_reads, 7);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("midreset prod_re", prod_re, 0);
    check_output("midreset orig_re", orig_re, 0);
    check_output("midreset out_valid", out_valid, 0);
    check_output("midreset out_data", out_data, 0);
    check_output("midreset range_err", range_err, 0);
    sticky = 1'b0;
    pq.delete();
    oq.delete();
    @(negedge clk);
    rst = 1'b0;
    random_prods(1'b1);
    run_hash("after reset", 1'b0, 0, 1'b1, got);

    for (int t = 0; t < 3; t++) begin
      random_prods(1'b0);
      run_hash("random", 1'($urandom_range(1, 0)), int'($urandom_range(4, 0)), 1'b0, got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
